// File: rtl/player_mover.sv
// Player pose owner: rate-limited turn/step updates, with each translation checked against
// the map over a req/ack grid port. Define WALL_SLIDE_EN to let blocked diagonals slide along one axis.
module player_mover #(
  parameter int X_W        = 15,
  parameter int Y_W        = 14,
  parameter int A_W        = 8,
  parameter int D_W        = 8,
  parameter int CELL_SHIFT = 9,
  parameter int CELL_W     = 3,
  parameter int TURN_STEP  = 10,
  parameter int TICK_W     = 20,
  parameter int INIT_X     = 1536,
  parameter int INIT_Y     = 1536,
  parameter int INIT_ANGLE = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    done,
  output logic                    busy,
  input  logic                    turn_right,
  input  logic                    turn_left,
  input  logic                    move_forward,
  input  logic                    move_backward,
  input  logic [D_W-1:0]          dir_x,
  input  logic [D_W-1:0]          dir_y,
  output logic [X_W-1:0]          pos_x,
  output logic [Y_W-1:0]          pos_y,
  output logic [A_W-1:0]          angle,
  output logic                    grid_req,
  output logic [X_W-CELL_SHIFT-1:0] grid_x,
  output logic [Y_W-CELL_SHIFT-1:0] grid_y,
  input  logic                    grid_ack,
  input  logic [CELL_W-1:0]       grid_cell
);

  localparam int GX_W = X_W - CELL_SHIFT;
  localparam int GY_W = Y_W - CELL_SHIFT;

  typedef enum logic [2:0] {
    IDLE,
    PREDICT,
    Q_XY,
`ifdef WALL_SLIDE_EN
    Q_X,
    Q_Y,
`endif
    COMMIT,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_q;
  logic [X_W-1:0]      posX_q, xPred_q;
  logic [Y_W-1:0]      posY_q, yPred_q;
  logic [A_W-1:0]      angle_q, angleNext_q;
  logic                commitX_q, commitY_q;
  logic                done_q, busy_q, gridReq_q;
  logic [GX_W-1:0]     gridX_q, gridX_d, xPredCell;
  logic [GY_W-1:0]     gridY_q, gridY_d, yPredCell;
`ifdef WALL_SLIDE_EN
  logic                xIn_q, yIn_q, diag_q;
  logic                diagC;
`endif

  logic signed [X_W:0] dxExt, xCurExt, xSum;
  logic signed [Y_W:0] dyExt, yCurExt, ySum;
  logic                fwd, bwd, moveReq, xInC, yInC;
  logic [A_W-1:0]      angleTurn;
  logic                accepted, cellFree, queryNext;

`ifdef WALL_SLIDE_EN
  // After a blocked diagonal, try the x axis first, then y; out-of-bounds axes are skipped.
  function automatic state_e slideStart(input logic xIn, input logic yIn, input logic diag);
    if (diag && xIn) return Q_X;
    if (diag && yIn) return Q_Y;
    return COMMIT;
  endfunction
`endif

  assign fwd     = move_forward && !move_backward;
  assign bwd     = move_backward && !move_forward;
  assign moveReq = fwd || bwd;

  assign dxExt   = {{(X_W + 1 - D_W){dir_x[D_W-1]}}, dir_x};
  assign dyExt   = {{(Y_W + 1 - D_W){dir_y[D_W-1]}}, dir_y};
  assign xCurExt = {1'b0, posX_q};
  assign yCurExt = {1'b0, posY_q};

  // Any true result beyond [0, 2^W) lands with the sign bit set in W+1 bits.
  always_comb begin
    xSum = xCurExt;
    ySum = yCurExt;
    if (fwd) begin
      xSum = xCurExt + dxExt;
      ySum = yCurExt + dyExt;
    end else if (bwd) begin
      xSum = xCurExt - dxExt;
      ySum = yCurExt - dyExt;
    end
  end

  assign xInC = !xSum[X_W];
  assign yInC = !ySum[Y_W];
`ifdef WALL_SLIDE_EN
  assign diagC = moveReq && (dir_x != '0) && (dir_y != '0);
`endif

  always_comb begin
    angleTurn = angle_q;
    if (turn_right && !turn_left)
      angleTurn = angle_q + A_W'(TURN_STEP);
    else if (turn_left && !turn_right)
      angleTurn = angle_q - A_W'(TURN_STEP);
  end

  assign accepted = gridReq_q && grid_ack;
  assign cellFree = (grid_cell == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (tick_q == '0)) state_d = PREDICT;
      PREDICT: begin
        if (!moveReq)
          state_d = COMMIT;
        else if (xInC && yInC)
          state_d = Q_XY;
        else begin
`ifdef WALL_SLIDE_EN
          state_d = slideStart(xInC, yInC, diagC);
`else
          state_d = COMMIT;
`endif
        end
      end
      Q_XY: begin
        if (accepted) begin
          if (cellFree)
            state_d = COMMIT;
          else begin
`ifdef WALL_SLIDE_EN
            state_d = slideStart(xIn_q, yIn_q, diag_q);
`else
            state_d = COMMIT;
`endif
          end
        end
      end
`ifdef WALL_SLIDE_EN
      Q_X: if (accepted) state_d = (cellFree || !yIn_q) ? COMMIT : Q_Y;
      Q_Y: if (accepted) state_d = COMMIT;
`endif
      COMMIT:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Query cells come from the live sum while predicting, from the stored prediction afterwards.
  assign xPredCell = (state_q == PREDICT) ? xSum[X_W-1:CELL_SHIFT] : xPred_q[X_W-1:CELL_SHIFT];
  assign yPredCell = (state_q == PREDICT) ? ySum[Y_W-1:CELL_SHIFT] : yPred_q[Y_W-1:CELL_SHIFT];

  always_comb begin
    gridX_d = posX_q[X_W-1:CELL_SHIFT];
    gridY_d = posY_q[Y_W-1:CELL_SHIFT];
    case (state_d)
      Q_XY: begin
        gridX_d = xPredCell;
        gridY_d = yPredCell;
      end
`ifdef WALL_SLIDE_EN
      Q_X:     gridX_d = xPredCell;
      Q_Y:     gridY_d = yPredCell;
`endif
      default: ;
    endcase
  end

`ifdef WALL_SLIDE_EN
  assign queryNext = (state_d == Q_XY) || (state_d == Q_X) || (state_d == Q_Y);
`else
  assign queryNext = (state_d == Q_XY);
`endif

  // An answered request always drops for a cycle, so a follow-up query shows a fresh rising edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      posX_q      <= X_W'(INIT_X);
      posY_q      <= Y_W'(INIT_Y);
      angle_q     <= A_W'(INIT_ANGLE);
      xPred_q     <= X_W'(INIT_X);
      yPred_q     <= Y_W'(INIT_Y);
      angleNext_q <= A_W'(INIT_ANGLE);
      commitX_q   <= 1'b0;
      commitY_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      gridReq_q   <= 1'b0;
      gridX_q     <= GX_W'(INIT_X >> CELL_SHIFT);
      gridY_q     <= GY_W'(INIT_Y >> CELL_SHIFT);
`ifdef WALL_SLIDE_EN
      xIn_q       <= 1'b0;
      yIn_q       <= 1'b0;
      diag_q      <= 1'b0;
`endif
    end else begin
      tick_q    <= tick_q + TICK_W'(1);
      state_q   <= state_d;
      gridX_q   <= gridX_d;
      gridY_q   <= gridY_d;
      gridReq_q <= queryNext && !accepted;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      case (state_q)
        PREDICT: begin
          xPred_q     <= xSum[X_W-1:0];
          yPred_q     <= ySum[Y_W-1:0];
          angleNext_q <= angleTurn;
          commitX_q   <= 1'b0;
          commitY_q   <= 1'b0;
`ifdef WALL_SLIDE_EN
          xIn_q       <= xInC;
          yIn_q       <= yInC;
          diag_q      <= diagC;
`endif
        end
        Q_XY: begin
          if (accepted && cellFree) begin
            commitX_q <= 1'b1;
            commitY_q <= 1'b1;
          end
        end
`ifdef WALL_SLIDE_EN
        Q_X: if (accepted && cellFree) commitX_q <= 1'b1;
        Q_Y: if (accepted && cellFree) commitY_q <= 1'b1;
`endif
        COMMIT: begin
          angle_q <= angleNext_q;
          if (commitX_q) posX_q <= xPred_q;
          if (commitY_q) posY_q <= yPred_q;
        end
        default: ;
      endcase
    end
  end

  assign done     = done_q;
  assign busy     = busy_q;
  assign pos_x    = posX_q;
  assign pos_y    = posY_q;
  assign angle    = angle_q;
  assign grid_req = gridReq_q;
  assign grid_x   = gridX_q;
  assign grid_y   = gridY_q;

endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover: the bench plays the map memory with a configurable ack delay.
// The tick counter is shortened so accept windows come every 8 cycles.
module tb_player_mover;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        done;
  logic        busy;
  logic        turn_right, turn_left, move_forward, move_backward;
  logic [7:0]  dir_x, dir_y;
  logic [14:0] pos_x;
  logic [13:0] pos_y;
  logic [7:0]  angle;
  logic        grid_req;
  logic [5:0]  grid_x;
  logic [4:0]  grid_y;
  logic        grid_ack;
  logic [2:0]  grid_cell;

  int   checks = 0;
  int   errors = 0;
  int   ackDelay = 1;
  logic wallOn = 1'b0;

  player_mover #(.TICK_W(3)) dut (
    .clock(clock), .reset(reset), .start(start), .done(done), .busy(busy),
    .turn_right(turn_right), .turn_left(turn_left),
    .move_forward(move_forward), .move_backward(move_backward),
    .dir_x(dir_x), .dir_y(dir_y), .pos_x(pos_x), .pos_y(pos_y), .angle(angle),
    .grid_req(grid_req), .grid_x(grid_x), .grid_y(grid_y),
    .grid_ack(grid_ack), .grid_cell(grid_cell)
  );

  always #5 clock = ~clock;

  // The map: everything free except an optional wall of type 2 at cell (3,3).
  function automatic logic [2:0] cellAt(input logic [5:0] gx, input logic [4:0] gy);
    return (wallOn && gx == 6'd3 && gy == 5'd3) ? 3'd2 : 3'd0;
  endfunction

  // Memory model: answers a held request after ackDelay cycles, for one cycle.
  initial begin : responder
    int waitCnt;
    waitCnt   = 0;
    grid_ack  = 1'b0;
    grid_cell = 3'd0;
    forever begin
      @(posedge clock); #1;
      if (grid_req && !grid_ack) begin
        if (waitCnt >= ackDelay) begin
          grid_ack  = 1'b1;
          grid_cell = cellAt(grid_x, grid_y);
        end else begin
          waitCnt++;
        end
      end else begin
        grid_ack = 1'b0;
        waitCnt  = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full update: wait for the accept, then count cycles and requests up to the done pulse.
  task automatic applyStimulus(input logic r, input logic l, input logic f, input logic b,
                               input int dx, input int dy,
                               output int lat, output int reqCyc, output int gx, output int gy);
    int n;
    turn_right = r; turn_left = l; move_forward = f; move_backward = b;
    dir_x = 8'(dx); dir_y = 8'(dy);
    start = 1'b1;
    n = 0; lat = 0; reqCyc = 0; gx = -1; gy = -1;
    while (!busy && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
    if (!busy) begin
      checks++; errors++;
      $error("[TB] FAIL acceptTimeout: observed busy=%0d expected 1", busy);
    end else begin
      lat = 1;
      while (!done && lat < 64) begin
        @(posedge clock); #1;
        lat++;
        if (grid_req) begin
          if (reqCyc == 0) begin
            gx = int'(grid_x);
            gy = int'(grid_y);
          end
          reqCyc++;
        end
      end
      if (!done) begin
        checks++; errors++;
        $error("[TB] FAIL doneTimeout: observed done=%0d expected 1", done);
      end
    end
    turn_right = 0; turn_left = 0; move_forward = 0; move_backward = 0;
    @(posedge clock); #1;
    checkOutput("donePulse", done, 0);
  endtask

  initial begin
    int lat, rq, gx, gy, n;
    reset = 1'b0; start = 1'b0;
    turn_right = 0; turn_left = 0; move_forward = 0; move_backward = 0;
    dir_x = 8'd0; dir_y = 8'd0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("rstPosX", pos_x, 1536);
    checkOutput("rstPosY", pos_y, 1536);
    checkOutput("rstAngle", angle, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstReq", grid_req, 0);
    checkOutput("rstGridX", grid_x, 3);
    checkOutput("rstGridY", grid_y, 3);

    // Start a query that the memory never answers, then reset in the middle of it.
    ackDelay = 1000;
    move_forward = 1;
    start = 1'b1;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("firstAccept", busy, 1);
    n = 0;
    while (!grid_req && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("reqBeforeReset", grid_req, 1);
    @(negedge clock); reset = 1'b0;
    #1;
    checkOutput("midRstReq", grid_req, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstDone", done, 0);
    checkOutput("midRstPosX", pos_x, 1536);
    checkOutput("midRstPosY", pos_y, 1536);
    checkOutput("midRstAngle", angle, 0);
    ackDelay = 1;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("reAccept", busy, 1);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("reDone", done, 1);
    move_forward = 0;
    @(posedge clock); #1;

    // Forward step into free cell (3,2) with a slow memory.
    ackDelay = 3;
    applyStimulus(0, 0, 1, 0, 20, -5, lat, rq, gx, gy);
    checkOutput("fwdReqCycles", rq, 4);
    checkOutput("fwdCellX", gx, 3);
    checkOutput("fwdCellY", gy, 2);
    checkOutput("fwdPosX", pos_x, 1556);
    checkOutput("fwdPosY", pos_y, 1531);
    checkOutput("fwdLatency", lat, 7);
    checkOutput("fwdIdleGridY", grid_y, 2);

    // 25 right turns reach 250; one more wraps to 4.
    ackDelay = 1;
    for (int i = 0; i < 25; i++) applyStimulus(1, 0, 0, 0, 0, 0, lat, rq, gx, gy);
    checkOutput("angle250", angle, 250);
    applyStimulus(1, 0, 0, 0, 0, 0, lat, rq, gx, gy);
    checkOutput("turnWrap", angle, 4);
    checkOutput("turnNoReq", rq, 0);
    checkOutput("turnLatency", lat, 3);
    checkOutput("turnPosX", pos_x, 1556);

    // Walk to (10,600).
    ackDelay = 0;
    for (int i = 0; i < 12; i++)
      applyStimulus(0, 0, 1, 0, -127, (i < 7) ? -127 : 0, lat, rq, gx, gy);
    applyStimulus(0, 0, 1, 0, -22, -42, lat, rq, gx, gy);
    checkOutput("walkPosX", pos_x, 10);
    checkOutput("walkPosY", pos_y, 600);

    // Backward step past x=0 is out of bounds: no query, no motion.
    applyStimulus(0, 0, 0, 1, 30, 0, lat, rq, gx, gy);
    checkOutput("oobNoReq", rq, 0);
    checkOutput("oobLatency", lat, 3);
    checkOutput("oobPosX", pos_x, 10);
    checkOutput("oobPosY", pos_y, 600);

    // Walk to (1500,1500) while turning left to angle 20.
    for (int i = 0; i < 11; i++)
      applyStimulus(0, 1, 1, 0, 127, (i < 7) ? 127 : 0, lat, rq, gx, gy);
    ackDelay = 1;
    applyStimulus(0, 1, 1, 0, 93, 11, lat, rq, gx, gy);
    checkOutput("moveLatency", lat, 5);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, 0, 0, 0, lat, rq, gx, gy);
    checkOutput("setupPosX", pos_x, 1500);
    checkOutput("setupPosY", pos_y, 1500);
    checkOutput("setupAngle", angle, 20);

    // Diagonal into the wall at (3,3); the x-only cell (3,2) is free.
    wallOn = 1'b1;
    applyStimulus(0, 1, 1, 0, 40, 40, lat, rq, gx, gy);
    checkOutput("wallCellX", gx, 3);
    checkOutput("wallCellY", gy, 3);
    checkOutput("wallAngle", angle, 10);
    checkOutput("wallPosY", pos_y, 1500);
`ifdef WALL_SLIDE_EN
    checkOutput("slidePosX", pos_x, 1540);
    checkOutput("slideReqCycles", rq, 4);
    checkOutput("slideLatency", lat, 8);
`else
    checkOutput("wallPosX", pos_x, 1500);
    checkOutput("wallReqCycles", rq, 2);
    checkOutput("wallLatency", lat, 5);
`endif
    wallOn = 1'b0;

    // All keys pressed cancel out.
    applyStimulus(1, 1, 1, 1, 50, 50, lat, rq, gx, gy);
    checkOutput("allKeysNoReq", rq, 0);
    checkOutput("allKeysLatency", lat, 3);
    checkOutput("allKeysAngle", angle, 10);
`ifdef WALL_SLIDE_EN
    checkOutput("allKeysPosX", pos_x, 1540);
`else
    checkOutput("allKeysPosX", pos_x, 1500);
`endif
    checkOutput("allKeysPosY", pos_y, 1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
